// File: rtl/fifo_sample_reader.sv
// fifo_sample_reader: drains a normal-mode FIFO into a framed valid/ready stream via a 2-entry skid buffer.
// Define FIFO_SAMPLE_READER_HEADER_EN to prefix each frame with {16'hA5A5, frame_count, cycle counter}.
module fifo_sample_reader #(
  parameter int DATA_WIDTH  = 64,
  parameter int FRAME_WORDS = 16
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  input  logic                  fifo_rdempty,
  input  logic                  fifo_rdfull,
  output logic                  fifo_rdreq,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [15:0]           frame_count,
  output logic                  overflow
);
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] b0_q, b0_d, b1_q, b1_d, m_data_q, m_data_d, hdr_word;
  logic [1:0] cnt_q, cnt_d, occ;
  logic inf_q, m_valid_q, m_valid_d, m_last_q, m_last_d, ovf_q, ovf_d;
  logic [15:0] idx_q, idx_d, fc_q, fc_d;
  logic hs, can_ld, pop, ld_hdr, idx_last;
`ifdef FIFO_SAMPLE_READER_HEADER_EN
  logic [31:0] cyc_q;
  always_ff @(posedge clk)
    if (!clear_n) cyc_q <= '0;
    else cyc_q <= cyc_q + 32'd1;
`endif
  always_comb begin
    hs = m_valid_q & m_ready;
    can_ld = !m_valid_q | m_ready;
    idx_last = idx_q == 16'(FRAME_WORDS - 1);
`ifdef FIFO_SAMPLE_READER_HEADER_EN
    // header goes out from IDLE, or directly behind the last word so frames cost only one extra cycle
    ld_hdr = cnt_q != 2'd0 && (state_q == IDLE ? can_ld : state_q == DATA && hs && m_last_q);
    pop = cnt_q != 2'd0 && !ld_hdr && (state_q == HDR ? hs : state_q == DATA && can_ld && !(m_valid_q && m_last_q));
    hdr_word = DATA_WIDTH'({16'hA5A5, fc_q, cyc_q});
`else
    ld_hdr = 1'b0;
    pop = cnt_q != 2'd0 && can_ld;
    hdr_word = '0;
`endif
    // occupancy after this cycle's pop, so streaming sustains one read per cycle
    occ = cnt_q - {1'b0, pop};
    fifo_rdreq = clear_n && enable && !fifo_rdempty && (occ + {1'b0, inf_q}) < 2'd2;
    b0_d = (inf_q && occ == 2'd0) ? fifo_q : pop ? b1_q : b0_q;
    b1_d = (inf_q && occ == 2'd1) ? fifo_q : b1_q;
    cnt_d = occ + {1'b0, inf_q};
    m_valid_d = ld_hdr | pop | (m_valid_q & !m_ready);
    m_data_d = ld_hdr ? hdr_word : pop ? b0_q : m_data_q;
    m_last_d = !ld_hdr && (pop ? idx_last : m_last_q);
    idx_d = pop ? (idx_last ? 16'd0 : idx_q + 16'd1) : idx_q;
    fc_d = fc_q + {15'd0, hs & m_last_q};
    ovf_d = ovf_q | fifo_rdfull;
    state_d = state_q;
    case (state_q)
`ifdef FIFO_SAMPLE_READER_HEADER_EN
      IDLE: if (ld_hdr) state_d = HDR;
`else
      IDLE: if (cnt_q != 2'd0) state_d = DATA;
`endif
      HDR: if (hs) state_d = DATA;
      DATA: if (hs && m_last_q) begin
        if (ld_hdr) state_d = HDR;
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!clear_n) begin
      state_q <= IDLE;
      b0_q <= '0;
      b1_q <= '0;
      cnt_q <= '0;
      inf_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q <= '0;
      m_last_q <= 1'b0;
      idx_q <= '0;
      fc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      b0_q <= b0_d;
      b1_q <= b1_d;
      cnt_q <= cnt_d;
      inf_q <= fifo_rdreq;
      m_valid_q <= m_valid_d;
      m_data_q <= m_data_d;
      m_last_q <= m_last_d;
      idx_q <= idx_d;
      fc_q <= fc_d;
      ovf_q <= ovf_d;
    end
  assign m_data = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last = m_last_q;
  assign frame_count = fc_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_fifo_sample_reader.sv
// tb_fifo_sample_reader: FIFO model feeding the reader, with an expected-word queue checked on every handshake.
module tb_fifo_sample_reader;
  logic clk = 1'b0, clear_n = 1'b0, enable = 1'b0, fifo_rdfull = 1'b0, m_ready = 1'b0;
  logic [63:0] fifo_q = '0;
  logic fifo_rdempty, fifo_rdreq, m_valid, m_last, overflow;
  logic [63:0] m_data;
  logic [15:0] frame_count;
  typedef struct packed {logic hdr; logic last; logic [63:0] data;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic [63:0] mem [0:255];
  int wr_cnt = 0, rd_count = 0, checks = 0, errors = 0, pos = 0, hdr_fc = 0;
  logic hold = 1'b0, have_cyc = 1'b0;
  logic [64:0] hold_v = '0;
  logic [31:0] last_cyc = '0;

  fifo_sample_reader dut (
    .clk(clk), .clear_n(clear_n), .enable(enable), .fifo_q(fifo_q),
    .fifo_rdempty(fifo_rdempty), .fifo_rdfull(fifo_rdfull), .fifo_rdreq(fifo_rdreq),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .frame_count(frame_count), .overflow(overflow)
  );

  always #5 clk = ~clk;
  assign fifo_rdempty = (wr_cnt == rd_count);

  always @(posedge clk)
    if (fifo_rdreq) begin
      fifo_q <= mem[rd_count[7:0]];
      rd_count <= rd_count + 1;
    end

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!clear_n) have_cyc = 1'b0;
    if (hold && m_valid) chk("hold_stable", {m_last, m_data}, hold_v);
    hold = m_valid && !m_ready;
    hold_v = {m_last, m_data};
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word actual=%h required=none", m_data);
      end else begin
        e = exp_q.pop_front();
        if (e.hdr) begin
          chk("hdr_tag", {1'b0, m_last, m_data[63:32]}, {1'b0, 1'b0, e.data[63:32]});
          if (have_cyc) chk("hdr_cycle_rises", 65'(m_data[31:0] > last_cyc), 65'(1));
          last_cyc = m_data[31:0];
          have_cyc = 1'b1;
        end else chk("data_word", {m_last, m_data}, {e.last, e.data});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [63:0] d);
    exp_t x;
    mem[wr_cnt[7:0]] = d;
    wr_cnt++;
`ifdef FIFO_SAMPLE_READER_HEADER_EN
    if (pos == 0) begin
      x = {1'b1, 1'b0, 16'hA5A5, hdr_fc[15:0], 32'h0};
      exp_q.push_back(x);
      hdr_fc++;
    end
`endif
    x = {1'b0, pos == 15, d};
    exp_q.push_back(x);
    pos = (pos + 1) % 16;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !m_valid) break;
      tick(1);
    end
    chk(name, 65'(exp_q.size()), 65'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int r0, base;
    enable = 1'b1;
    tick(1);
    for (int i = 0; i < 32; i++) push_word(64'(i));
    tick(3);
    @(negedge clk);
    chk("rst_rdreq", 65'(fifo_rdreq), 65'(0));
    chk("rst_out", {m_valid, m_last, m_data}, 65'(0));
    chk("rst_frames", 65'(frame_count), 65'(0));
    chk("rst_overflow", 65'(overflow), 65'(0));
    @(posedge clk);
    #1 clear_n = 1'b1;
    @(negedge clk) chk("release_rdreq", 65'(fifo_rdreq), 65'(1));
    @(negedge clk) chk("lat_edge_n", 65'(m_valid), 65'(0));
    @(negedge clk) chk("lat_edge_n1", 65'(m_valid), 65'(0));
    @(negedge clk) chk("lat_edge_n2", 65'(m_valid), 65'(1));
    tick(1);
    m_ready = 1'b1;
    drain("stream_drain");
    chk("stream_frames", 65'(frame_count), 65'(2));

    for (int i = 0; i < 16; i++) push_word(64'(32'h100 + i));
    tick(4);
    m_ready = 1'b0;
    r0 = rd_count;
    tick(10);
    chk("bp_extra_reads", 65'(rd_count - r0 <= 1), 65'(1));
    m_ready = 1'b1;
    drain("bp_drain");
    chk("bp_frames", 65'(frame_count), 65'(3));

    base = rd_count;
    for (int i = 0; i < 16; i++) push_word(64'(32'h200 + i));
    for (int i = 0; i < 50; i++) begin
      if (rd_count - base >= 5) break;
      tick(1);
    end
    enable = 1'b0;
    tick(10);
    chk("gap_reads", 65'(rd_count - base), 65'(5));
    chk("gap_idle_valid", 65'(m_valid), 65'(0));
    chk("gap_frames", 65'(frame_count), 65'(3));
    enable = 1'b1;
    drain("gap_drain");
    chk("gap_frames_done", 65'(frame_count), 65'(4));

    chk("ovf_before", 65'(overflow), 65'(0));
    fifo_rdfull = 1'b1;
    tick(1);
    fifo_rdfull = 1'b0;
    @(negedge clk) chk("ovf_set", 65'(overflow), 65'(1));
    tick(3);
    chk("ovf_sticky", 65'(overflow), 65'(1));
    for (int i = 0; i < 20; i++) push_word(64'(32'h300 + i));
    tick(7);
    clear_n = 1'b0;
    m_ready = 1'b0;
    exp_q.delete();
    wr_cnt = rd_count;
    pos = 0;
    hdr_fc = 0;
    tick(2);
    chk("clr_overflow", 65'(overflow), 65'(0));
    chk("clr_frames", 65'(frame_count), 65'(0));
    chk("clr_valid", 65'(m_valid), 65'(0));
    clear_n = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_word(64'(32'h400 + i));
    drain("clr_drain");
    chk("clr_frames_done", 65'(frame_count), 65'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
